// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit -- multi-cycle 32-bit integer divider for the MIPS EX stage.
//
// Accepts a DIV (signed) or DIVU (unsigned) request and produces one quotient
// bit per clock using restoring division. The result is returned as
// {remainder, quotient} so EX can write HI/LO.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset
//   signed_div_in  1 = DIV (signed), 0 = DIVU
//   opdata1_in     dividend
//   opdata2_in     divisor
//   start_in       request level, held by EX until the result is consumed
//   annul_in       cancels a pending or in-flight division
//   result_out     {remainder[31:0], quotient[31:0]}, registered
//   ready_out      result valid, registered
// ---------------------------------------------------------------------------
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_in,
    input  logic [31:0] opdata1_in,
    input  logic [31:0] opdata2_in,
    input  logic        start_in,
    input  logic        annul_in,
    output logic [63:0] result_out,
    output logic        ready_out
);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    // Working register: [64:32] partial remainder, [31:0] dividend bits that
    // are consumed from the top while quotient bits shift in at the bottom.
    logic [64:0] work;
    logic [31:0] divisor_mag;
    logic        signed_op;
    logic        sign1;
    logic        sign2;

    // Operand magnitudes (only used when a request is accepted in FREE).
    logic [31:0] mag1;
    logic [31:0] mag2;

    // One restoring step.
    logic [33:0] trial;
    logic        ge;
    logic [32:0] partial_next;
    logic [31:0] low_next;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    always_comb begin
        mag1 = (signed_div_in && opdata1_in[31]) ? (~opdata1_in + 32'd1) : opdata1_in;
        mag2 = (signed_div_in && opdata2_in[31]) ? (~opdata2_in + 32'd1) : opdata2_in;

        // Shift the next dividend bit into the partial remainder.
        trial        = {work[64:32], work[31]};
        ge           = (trial >= {2'b00, divisor_mag});
        partial_next = ge ? (trial[32:0] - {1'b0, divisor_mag}) : trial[32:0];
        low_next     = {work[30:0], ge};

        // After the final step low_next holds the full quotient magnitude.
        quot_fix = (signed_op && (sign1 ^ sign2)) ? (~low_next + 32'd1) : low_next;
        rem_fix  = (signed_op && sign1) ? (~partial_next[31:0] + 32'd1) : partial_next[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_FREE;
            cnt         <= 6'd0;
            work        <= 65'd0;
            divisor_mag <= 32'd0;
            signed_op   <= 1'b0;
            sign1       <= 1'b0;
            sign2       <= 1'b0;
            result_out  <= 64'd0;
            ready_out   <= 1'b0;
        end else begin
            case (state)
                ST_FREE: begin
                    ready_out  <= 1'b0;
                    result_out <= 64'd0;
                    if (start_in && !annul_in) begin
                        if (opdata2_in == 32'd0) begin
                            state <= ST_BYZERO;
                        end else begin
                            state       <= ST_ON;
                            cnt         <= 6'd0;
                            // Remainder half cleared; dividend magnitude loaded
                            // into the half that the steps consume.
                            work        <= {33'd0, mag1};
                            divisor_mag <= mag2;
                            signed_op   <= signed_div_in;
                            sign1       <= opdata1_in[31];
                            sign2       <= opdata2_in[31];
                        end
                    end
                end

                ST_BYZERO: begin
                    result_out <= 64'd0;
                    if (annul_in) begin
                        state     <= ST_FREE;
                        ready_out <= 1'b0;
                    end else begin
                        state     <= ST_END;
                        ready_out <= 1'b1;
                    end
                end

                ST_ON: begin
                    if (annul_in) begin
                        state      <= ST_FREE;
                        cnt        <= 6'd0;
                        result_out <= 64'd0;
                        ready_out  <= 1'b0;
                    end else begin
                        work       <= {partial_next, low_next};
                        cnt        <= cnt + 6'd1;
                        result_out <= {rem_fix, quot_fix};
                        if (cnt == 6'd31) begin
                            state     <= ST_END;
                            ready_out <= 1'b1;
                        end
                    end
                end

                ST_END: begin
                    if (!start_in || annul_in) begin
                        state      <= ST_FREE;
                        cnt        <= 6'd0;
                        ready_out  <= 1'b0;
                        result_out <= 64'd0;
                    end
                end

                default: begin
                    state      <= ST_FREE;
                    ready_out  <= 1'b0;
                    result_out <= 64'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// ---------------------------------------------------------------------------
// tb_div_unit -- self-checking bench for div_unit.
// A driver issues directed divisions and pushes the hand-computed result and
// latency into a scoreboard queue; a monitor pops and compares each time
// ready_out rises.
// ---------------------------------------------------------------------------
module tb_div_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_in;
    logic [31:0] opdata1_in;
    logic [31:0] opdata2_in;
    logic        start_in;
    logic        annul_in;
    logic [63:0] result_out;
    logic        ready_out;

    div_unit dut (
        .clk           (clk),
        .rst           (rst),
        .signed_div_in (signed_div_in),
        .opdata1_in    (opdata1_in),
        .opdata2_in    (opdata2_in),
        .start_in      (start_in),
        .annul_in      (annul_in),
        .result_out    (result_out),
        .ready_out     (ready_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] res;
        int          lat;
        int          issue;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    // Monitor: compare on every rising ready_out.
    initial begin : monitor
        logic ready_d;
        exp_t e;
        ready_d = 1'b0;
        forever begin
            @(negedge clk);
            if (ready_out === 1'b1 && ready_d !== 1'b1) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ready", {63'd0, ready_out}, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", result_out, e.res);
                    check("latency", 64'(cyc - e.issue - 1), 64'(e.lat));
                end
            end
            ready_d = ready_out;
        end
    end

    // Issue one division, wait for ready, release start and check the clear.
    task automatic run_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp, input int lat);
        exp_t e;
        @(negedge clk);
        e.res = exp; e.lat = lat; e.issue = cyc;
        sb_q.push_back(e);
        signed_div_in = s; opdata1_in = a; opdata2_in = b; start_in = 1'b1;
        for (int i = 0; i < 40 && ready_out !== 1'b1; i++) @(negedge clk);
        if (ready_out !== 1'b1) begin
            check("ready_timeout", {63'd0, ready_out}, 64'd1);
            sb_q.delete();
        end
        // Operand changes while END is held must not disturb the result.
        opdata1_in = 32'h1234_5678; opdata2_in = 32'd3; signed_div_in = ~s;
        @(negedge clk);
        check("held_result", result_out, exp);
        start_in = 1'b0;
        @(negedge clk);
        check("drop_ready", {63'd0, ready_out}, 64'd0);
        check("drop_result", result_out, 64'd0);
    endtask

    initial begin : driver
        int hits;
        rst = 1'b1; start_in = 1'b0; annul_in = 1'b0; signed_div_in = 1'b0;
        opdata1_in = 32'd0; opdata2_in = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_ready", {63'd0, ready_out}, 64'd0);
        check("reset_result", result_out, 64'd0);
        rst = 1'b0;

        run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 32);
        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 32);
        run_div(1'b1, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 32);
        run_div(1'b0, 32'hFFFFFFF9, 32'd2, 64'h00000001_7FFFFFFC, 32);
        run_div(1'b0, 32'd1234, 32'd0, 64'h0, 1);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 32);
        run_div(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 32);

        // Start with annul held: must stay idle.
        @(negedge clk);
        signed_div_in = 1'b0; opdata1_in = 32'd10; opdata2_in = 32'd3;
        start_in = 1'b1; annul_in = 1'b1;
        hits = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready_out === 1'b1) hits++;
        end
        check("annul_start_ready", 64'(hits), 64'd0);
        start_in = 1'b0; annul_in = 1'b0;

        // Annul at step 10 of 1000/3.
        @(negedge clk);
        opdata1_in = 32'd1000; opdata2_in = 32'd3; start_in = 1'b1;
        repeat (11) @(negedge clk);
        annul_in = 1'b1; start_in = 1'b0;
        @(negedge clk);
        annul_in = 1'b0;
        hits = 0;
        repeat (40) begin
            if (ready_out === 1'b1) hits++;
            @(negedge clk);
        end
        check("annul_on_ready", 64'(hits), 64'd0);
        run_div(1'b0, 32'd1000, 32'd3, 64'h00000001_0000014D, 32);

        // Asynchronous reset in the middle of ON.
        @(negedge clk);
        opdata1_in = 32'd100; opdata2_in = 32'd7; start_in = 1'b1;
        repeat (10) @(negedge clk);
        @(posedge clk);
        #3;
        start_in = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst_ready", {63'd0, ready_out}, 64'd0);
        check("async_rst_result", result_out, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 32);

        repeat (3) @(negedge clk);
        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
